gbsha_fir_seq: RTL and testbench



---
 rtl/gbsha_fir_pkg.sv | 51 +++++
 rtl/gbsha_fir_mac.sv | 39 +++
 rtl/gbsha_fir_seq.sv | 163 ++++++++++++++++
 tb/tb_gbsha_fir_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbsha_fir_pkg.sv
// Shared types and helpers for the gbsha_fir_seq time-multiplexed FIR filter.
// Optional build macro: GBSHA_FIR_SAT_EN (saturating, round-half-up output format).
package gbsha_fir_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    // Working width for the output formatter; wide enough that rounding and
    // shifting can never overflow for any sane accumulator width.
    localparam int FMT_W = 64;

    // Full-precision accumulator width: one product plus growth for the tap sum.
    function automatic int acc_width(input int bw_in, input int bw_coef, input int n_taps);
        return bw_in + bw_coef + $clog2(n_taps);
    endfunction

    // Width of the tap index counter.
    function automatic int idx_width(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    // Round half-up, arithmetic shift, then clamp to the signed bw_out range.
    function automatic logic signed [FMT_W-1:0] sat_round(
        input logic signed [FMT_W-1:0] a,
        input int                      shift,
        input int                      bw_out
    );
        logic signed [FMT_W-1:0] rounded;
        logic signed [FMT_W-1:0] shifted;
        logic signed [FMT_W-1:0] hi;
        logic signed [FMT_W-1:0] lo;
        if (shift > 0) begin
            rounded = a + (64'sd1 <<< (shift - 1));
        end else begin
            rounded = a;
        end
        shifted = rounded >>> shift;
        hi      = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (bw_out - 1));
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/gbsha_fir_mac.sv
// Signed multiply-accumulate slice: combinational product, registered
// accumulator with synchronous clear. `sum` is acc + current product, so the
// caller can capture the final tap result without waiting another cycle.
module gbsha_fir_mac #(
    parameter int BW_A   = 4,
    parameter int BW_B   = 4,
    parameter int BW_ACC = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [BW_A-1:0]   a,
    input  logic [BW_B-1:0]   b,
    output logic [BW_ACC-1:0] sum
);

    logic signed [BW_A+BW_B-1:0] prod_s;
    logic signed [BW_ACC-1:0]    acc_r;
    logic signed [BW_ACC-1:0]    total_s;

    assign prod_s  = $signed(a) * $signed(b);
    assign total_s = acc_r + BW_ACC'(prod_s);
    assign sum     = total_s;

    // Accumulator: cleared at sample accept, adds one product per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= total_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/gbsha_fir_seq.sv
// N-tap signed FIR with serially loadable coefficients and one shared MAC.
// A sample is accepted in IDLE, then N_TAPS MAC cycles walk the taps and the
// last one registers the formatted result with a one-cycle out_valid pulse.
// Optional build macro: GBSHA_FIR_SAT_EN selects saturate + round-half-up
// output formatting instead of truncate + wrap.
module gbsha_fir_seq
    import gbsha_fir_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int BW_in     = 4,
    parameter int BW_coef   = 4,
    parameter int BW_out    = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BW_in-1:0]   x_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW_coef-1:0] coef_in,
    input  logic               coef_valid,
    output logic [BW_out-1:0]  y_out,
    output logic               out_valid
);

    localparam int BW_ACC = acc_width(BW_in, BW_coef, N_TAPS);
    localparam int IDX_W  = idx_width(N_TAPS);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [BW_in-1:0]        x_hist_r [N_TAPS];
    logic [BW_coef-1:0]      coef_r   [N_TAPS];
    logic [IDX_W-1:0]        idx_r;
    logic                    accept_s;
    logic                    coef_load_s;
    logic                    last_s;
    logic                    mac_en_s;
    logic [BW_in-1:0]        x_sel_s;
    logic [BW_coef-1:0]      coef_sel_s;
    logic [BW_ACC-1:0]       mac_sum_s;
    logic signed [FMT_W-1:0] wide_s;
    logic [BW_out-1:0]       y_fmt_s;

    // A coefficient strobe in IDLE wins over a pending sample.
    assign in_ready    = (state_r == IDLE) && !coef_valid;
    assign accept_s    = in_valid && in_ready;
    assign coef_load_s = (state_r == IDLE) && coef_valid;
    assign mac_en_s    = (state_r == MAC);
    assign last_s      = (state_r == MAC) && (idx_r == IDX_W'(N_TAPS - 1));
    assign x_sel_s     = x_hist_r[idx_r];
    assign coef_sel_s  = coef_r[idx_r];
    assign wide_s      = FMT_W'($signed(mac_sum_s));

    gbsha_fir_mac #(
        .BW_A   (BW_in),
        .BW_B   (BW_coef),
        .BW_ACC (BW_ACC)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (accept_s),
        .en    (mac_en_s),
        .a     (x_sel_s),
        .b     (coef_sel_s),
        .sum   (mac_sum_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: IDLE -> MAC on accept, MAC -> IDLE after the last tap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = MAC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAC: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MAC;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Tap index: restarts at accept, steps once per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r <= '0;
        end else if (accept_s) begin
            idx_r <= '0;
        end else if (state_r == MAC) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Sample history: newest sample enters at tap 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_hist_r[k] <= '0;
            end
        end else if (accept_s) begin
            x_hist_r[0] <= x_in;
            for (int k = 1; k < N_TAPS; k++) begin
                x_hist_r[k] <= x_hist_r[k-1];
            end
        end
    end

    // Coefficient chain: loads enter at the top so c0 ends up in tap 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                coef_r[k] <= (k == 0) ? BW_coef'(1'b1) : '0;
            end
        end else if (coef_load_s) begin
            coef_r[N_TAPS-1] <= coef_in;
            for (int k = 0; k < N_TAPS - 1; k++) begin
                coef_r[k] <= coef_r[k+1];
            end
        end
    end

    // Output formatter applied to acc + last product.
    always_comb begin
        y_fmt_s = '0;
`ifdef GBSHA_FIR_SAT_EN
        y_fmt_s = BW_out'(sat_round(wide_s, OUT_SHIFT, BW_out));
`else
        y_fmt_s = BW_out'(wide_s >>> OUT_SHIFT);
`endif
    end

    // Result register and its one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= last_s;
            if (last_s) begin
                y_out <= y_fmt_s;
            end
        end
    end

endmodule

// File: tb/tb_gbsha_fir_seq.sv
// Self-checking bench for gbsha_fir_seq: a transaction-level model checked
// every cycle, directed scenarios with hand-computed results, random traffic.
// Optional build macro: GBSHA_FIR_SAT_EN (changes the overflow expectations).
module tb_gbsha_fir_seq;

    localparam int N   = 4;
    localparam int BWI = 4;
    localparam int BWC = 4;
    localparam int BWO = 8;
    localparam int SH  = 0;

    logic           clk        = 1'b0;
    logic           reset      = 1'b1;
    logic [BWI-1:0] x_in       = '0;
    logic           in_valid   = 1'b0;
    logic           in_ready;
    logic [BWC-1:0] coef_in    = '0;
    logic           coef_valid = 1'b0;
    logic [BWO-1:0] y_out;
    logic           out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gbsha_fir_seq #(
        .N_TAPS    (N),
        .BW_in     (BWI),
        .BW_coef   (BWC),
        .BW_out    (BWO),
        .OUT_SHIFT (SH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .y_out      (y_out),
        .out_valid  (out_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint     m_coef [N];
    longint     m_hist [N];
    int         m_busy = 0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_y    = 8'h00;
    logic       m_valid = 1'b0;

    function automatic logic [7:0] fmt(input longint a);
        longint s;
        longint v;
        v = a;
`ifdef GBSHA_FIR_SAT_EN
        if (SH > 0) v = v + (longint'(1) << ((SH > 0) ? SH - 1 : 0));
        s = v >>> SH;
        if (s > (longint'(1) << (BWO - 1)) - 1) s = (longint'(1) << (BWO - 1)) - 1;
        if (s < -(longint'(1) << (BWO - 1)))    s = -(longint'(1) << (BWO - 1));
`else
        s = v >>> SH;
`endif
        return s[7:0];
    endfunction

    task automatic model_step();
        longint acc;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_hist[k] = 0;
                m_coef[k] = (k == 0) ? 1 : 0;
            end
            m_busy  = 0;
            m_valid = 1'b0;
            m_y     = 8'h00;
        end else begin
            m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_y     = m_pend;
                end
            end else if (coef_valid) begin
                for (int k = 0; k < N - 1; k++) m_coef[k] = m_coef[k+1];
                m_coef[N-1] = longint'($signed(coef_in));
            end else if (in_valid) begin
                for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = longint'($signed(x_in));
                acc = 0;
                for (int k = 0; k < N; k++) acc += m_hist[k] * m_coef[k];
                m_pend = fmt(acc);
                m_busy = N;
            end
        end
    endtask

    // Model advances on each rising edge; DUT compared on each falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("y_out", 64'(y_out), 64'(m_y));
            chk("in_ready", 64'(in_ready), 64'((m_busy == 0) && !coef_valid));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int c);
        step();
        coef_valid = 1'b1;
        coef_in    = 4'(c);
        step();
        coef_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [7:0] exp, input string name);
        bit got;
        int lat;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (got) begin
            chk({name, "_latency"}, 64'(lat), 64'(N));
            chk(name, 64'(y_out), 64'(exp));
        end else begin
            chk({name, "_timeout"}, 64'(0), 64'(1));
        end
    endtask

    task automatic send(input int x, input logic [7:0] exp, input string name);
        bit ok;
        ok = 1'b0;
        step();
        in_valid = 1'b1;
        x_in     = 4'(x);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        step();
        in_valid = 1'b0;
        if (!ok) chk({name, "_ready_timeout"}, 64'(0), 64'(1));
        else     wait_out(exp, name);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int  accepts;
        int  last_acc;
        int  pulses;
        bit  acc_now;

        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_y_out", 64'(y_out), 64'(8'h00));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));

        // 1. identity filter after reset
        send(3, 8'h03, "identity_3");
        send(-5, 8'hFB, "identity_m5");

        // 2. coefficient load and impulse response
        do_reset();
        load(1); load(2); load(3); load(4);
        send(1, 8'h01, "impulse_0");
        send(0, 8'h02, "impulse_1");
        send(0, 8'h03, "impulse_2");
        send(0, 8'h04, "impulse_3");
        send(0, 8'h00, "impulse_4");

        // 3. overflow behaviour
        load(-8); load(-8); load(-8); load(-8);
`ifdef GBSHA_FIR_SAT_EN
        send(-8, 8'd64,  "ovf_0");
        send(-8, 8'd127, "ovf_1");
        send(-8, 8'd127, "ovf_2");
        send(-8, 8'd127, "ovf_3");
`else
        send(-8, 8'd64,  "ovf_0");
        send(-8, 8'h80,  "ovf_1");
        send(-8, 8'hC0,  "ovf_2");
        send(-8, 8'h00,  "ovf_3");
`endif

        // 4. held in_valid: one accept per N+1 cycles, mid-MAC coef pulse ignored
        do_reset();
        step();
        in_valid = 1'b1;
        x_in     = 4'(2);
        accepts  = 0;
        last_acc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) begin
                accepts++;
                if (last_acc >= 0) chk("accept_spacing", 64'(c - last_acc), 64'(N + 1));
                last_acc = c;
            end
            step();
            coef_valid = (c == 7);
            coef_in    = 4'(7);
        end
        in_valid   = 1'b0;
        coef_valid = 1'b0;
        chk("accept_count", 64'(accepts), 64'(4));
        repeat (8) step();
        chk("held_result", 64'(y_out), 64'(8'h02));

        // 5. coef_valid has priority over in_valid
        step();
        coef_valid = 1'b1;
        coef_in    = 4'(3);
        in_valid   = 1'b1;
        x_in       = 4'(1);
        @(negedge clk);
        chk("priority_ready_low", 64'(in_ready), 64'(0));
        step();
        coef_valid = 1'b0;
        @(negedge clk);
        chk("priority_ready_high", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        wait_out(8'h06, "priority_result");

        // 6. reset in the middle of a MAC
        step();
        in_valid = 1'b1;
        x_in     = 4'(5);
        @(negedge clk);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_valid", 64'(pulses), 64'(0));
        chk("abort_y_out", 64'(y_out), 64'(8'h00));
        send(4, 8'h04, "after_abort");

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            step();
            reset = ($urandom_range(0, 149) == 0);
            if (acc_now || !in_valid) begin
                in_valid = ($urandom_range(0, 2) != 0);
                x_in     = 4'($urandom);
            end
            coef_valid = ($urandom_range(0, 5) == 0);
            coef_in    = 4'($urandom);
        end
        step();
        reset      = 1'b0;
        in_valid   = 1'b0;
        coef_valid = 1'b0;
        repeat (10) step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
